// File: rtl/r4_frac_div_seq_pkg.sv
// Shared types, digit-selection thresholds and width helpers for the radix-4 SRT divider.
package r4_frac_div_pkg;

    typedef logic signed [6:0] est_t;
    typedef logic [4:0]        digit_t;

    localparam digit_t DIG_P2 = 5'b00001;
    localparam digit_t DIG_P1 = 5'b00010;
    localparam digit_t DIG_Z  = 5'b00100;
    localparam digit_t DIG_M1 = 5'b01000;
    localparam digit_t DIG_M2 = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_POST = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Thresholds in eighths, indexed by divisor interval d in [1+i/8, 1+(i+1)/8).
    localparam est_t M_P2 [8] = '{7'sd12, 7'sd14, 7'sd16, 7'sd16, 7'sd18, 7'sd20, 7'sd20, 7'sd24};
    localparam est_t M_P1 [8] = '{7'sd3, 7'sd4, 7'sd4, 7'sd4, 7'sd6, 7'sd6, 7'sd8, 7'sd8};
    localparam est_t M_Z  [8] = '{-7'sd4, -7'sd4, -7'sd6, -7'sd6, -7'sd6, -7'sd8, -7'sd8, -7'sd8};
    localparam est_t M_M1 [8] = '{-7'sd13, -7'sd14, -7'sd16, -7'sd16, -7'sd18, -7'sd20, -7'sd20, -7'sd24};

    function automatic int calc_n(input int width);
        return width / 2 + 2;
    endfunction

    function automatic int calc_qw(input int width);
        return 2 * calc_n(width) - 1;
    endfunction

    function automatic int calc_rem_w(input int width);
        return width + 5;
    endfunction

endpackage

// File: rtl/r4_frac_div_seq_if.sv
// Operand/result handshake bundle between the unpacker, the divider and the rounder.
interface r4_frac_div_seq_if
    import r4_frac_div_pkg::*;
#(
    parameter int WIDTH = 24
);
    localparam int QW = calc_qw(WIDTH);

    logic             start_valid_i;
    logic             start_ready_o;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             flush_i;
    logic             finish_valid_o;
    logic             finish_ready_i;
    logic [QW-1:0]    quo_o;
    logic             rem_zero_o;

    modport slave (
        input  start_valid_i, dividend_i, divisor_i, flush_i, finish_ready_i,
        output start_ready_o, finish_valid_o, quo_o, rem_zero_o
    );

    modport master (
        output start_valid_i, dividend_i, divisor_i, flush_i, finish_ready_i,
        input  start_ready_o, finish_valid_o, quo_o, rem_zero_o
    );
endinterface

// File: rtl/r4_frac_div_seq_qds.sv
// Radix-4 quotient digit selector: 7-bit remainder estimate and divisor interval in,
// one-hot digit out. QDS_ARCH picks the comparator style; all three are equivalent.
module r4_qds_v3
    import r4_frac_div_pkg::*;
#(
    parameter int QDS_ARCH = 0
) (
    input  est_t       est_i,
    input  logic [2:0] idx_i,
    output digit_t     digit_o
);
    est_t       thr [4];
    logic [3:0] ge;

    always_comb begin
        thr[0] = M_P2[idx_i];
        thr[1] = M_P1[idx_i];
        thr[2] = M_Z[idx_i];
        thr[3] = M_M1[idx_i];
    end

    generate
        if (QDS_ARCH == 1) begin : g_cmp
            // Flipping the sign bit maps two's complement order onto unsigned order.
            always_comb begin
                for (int k = 0; k < 4; k++)
                    ge[k] = {~est_i[6], est_i[5:0]} >= {~thr[k][6], thr[k][5:0]};
            end
        end else if (QDS_ARCH == 2) begin : g_add
            logic [7:0] diff [4];
            always_comb begin
                for (int k = 0; k < 4; k++) begin
                    diff[k] = {est_i[6], est_i} - {thr[k][6], thr[k]};
                    ge[k]   = $signed(diff[k]) >= 8'sd0;
                end
            end
        end else begin : g_native
            always_comb begin
                for (int k = 0; k < 4; k++)
                    ge[k] = est_i >= thr[k];
            end
        end
    endgenerate

    always_comb begin
        if (ge[0])      digit_o = DIG_P2;
        else if (ge[1]) digit_o = DIG_P1;
        else if (ge[2]) digit_o = DIG_Z;
        else if (ge[3]) digit_o = DIG_M1;
        else            digit_o = DIG_M2;
    end
endmodule

// File: rtl/r4_frac_div_seq.sv
// Sequential radix-4 SRT mantissa divider, one digit per cycle with on-the-fly conversion.
// States: IDLE wait operands | ITER one digit per cycle | POST sign fix + sticky | DONE hold result
module r4_frac_div_seq
    import r4_frac_div_pkg::*;
#(
    parameter int WIDTH    = 24,
    parameter int QDS_ARCH = 0
) (
    input logic               clk,
    input logic               rst_n,
    r4_frac_div_seq_if.slave  bus
);
    localparam int N     = calc_n(WIDTH);
    localparam int QW    = calc_qw(WIDTH);
    localparam int REM_W = calc_rem_w(WIDTH);
    localparam int CW    = $clog2(N);

    state_e                   state_q, state_d;
    logic signed [REM_W-1:0]  w_q, d_q, w4, w_nxt, w_corr;
    logic [2:0]               idx_q;
    logic [QW-1:0]            q_q, qm_q, q_nxt, qm_nxt, quo_q;
    logic                     rem_zero_q;
    logic [CW-1:0]            cnt_q;
    logic                     accept;
    est_t                     est;
    digit_t                   digit;

    // Remainder carries WIDTH+1 fraction bits; estimate is 4w floored to eighths.
    assign w4     = w_q <<< 2;
    assign est    = w4[REM_W-1 -: 7];
    assign w_corr = w_q + d_q;
    assign accept = (state_q == ST_IDLE) && bus.start_valid_i && !bus.flush_i;

    r4_qds_v3 #(.QDS_ARCH(QDS_ARCH)) u_qds (
        .est_i   (est),
        .idx_i   (idx_q),
        .digit_o (digit)
    );

    always_comb begin
        w_nxt  = w4;
        q_nxt  = {q_q[QW-3:0], 2'd0};
        qm_nxt = {qm_q[QW-3:0], 2'd3};
        case (digit)
            DIG_P2: begin
                w_nxt  = w4 - (d_q <<< 1);
                q_nxt  = {q_q[QW-3:0], 2'd2};
                qm_nxt = {q_q[QW-3:0], 2'd1};
            end
            DIG_P1: begin
                w_nxt  = w4 - d_q;
                q_nxt  = {q_q[QW-3:0], 2'd1};
                qm_nxt = {q_q[QW-3:0], 2'd0};
            end
            DIG_M1: begin
                w_nxt  = w4 + d_q;
                q_nxt  = {qm_q[QW-3:0], 2'd3};
                qm_nxt = {qm_q[QW-3:0], 2'd2};
            end
            DIG_M2: begin
                w_nxt  = w4 + (d_q <<< 1);
                q_nxt  = {qm_q[QW-3:0], 2'd2};
                qm_nxt = {qm_q[QW-3:0], 2'd1};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.start_valid_i) state_d = ST_ITER;
                ST_ITER: if (cnt_q == '0)       state_d = ST_POST;
                ST_POST: state_d = ST_DONE;
                ST_DONE: if (bus.finish_ready_i) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.start_ready_o  = (state_q == ST_IDLE);
        bus.finish_valid_o = (state_q == ST_DONE);
        bus.quo_o          = quo_q;
        bus.rem_zero_o     = rem_zero_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_q        <= '0;
            d_q        <= '0;
            idx_q      <= '0;
            q_q        <= '0;
            qm_q       <= '0;
            cnt_q      <= '0;
            quo_q      <= '0;
            rem_zero_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    w_q   <= {{(REM_W-WIDTH){1'b0}}, bus.dividend_i};
                    d_q   <= {3'b000, bus.divisor_i, 2'b00};
                    idx_q <= bus.divisor_i[WIDTH-2 -: 3];
                    q_q   <= '0;
                    qm_q  <= '0;
                    cnt_q <= CW'(N-1);
                end
                ST_ITER: begin
                    w_q  <= w_nxt;
                    q_q  <= q_nxt;
                    qm_q <= qm_nxt;
                    if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                end
                ST_POST: if (!bus.flush_i) begin
                    if (w_q[REM_W-1]) begin
                        quo_q      <= qm_q;
                        w_q        <= w_corr;
                        rem_zero_q <= (w_corr == '0);
                    end else begin
                        quo_q      <= q_q;
                        rem_zero_q <= (w_q == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_r4_frac_div_seq.sv
// Scoreboard bench for r4_frac_div_seq: digit-selector sweep, directed corners, control and random ops.
module tb_r4_frac_div_seq;
    import r4_frac_div_pkg::*;

    localparam int WIDTH = 24;
    localparam int N     = calc_n(WIDTH);
    localparam int QW    = calc_qw(WIDTH);

    typedef struct packed {
        logic [QW-1:0] quo;
        logic          rz;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb [$];

    est_t       qy;
    logic [2:0] qi;
    digit_t     qd0, qd1, qd2;

    int t_p2 [8] = '{12, 14, 16, 16, 18, 20, 20, 24};
    int t_p1 [8] = '{3, 4, 4, 4, 6, 6, 8, 8};
    int t_z  [8] = '{-4, -4, -6, -6, -6, -8, -8, -8};
    int t_m1 [8] = '{-13, -14, -16, -16, -18, -20, -20, -24};

    always #5 clk = ~clk;

    r4_frac_div_seq_if #(.WIDTH(WIDTH)) bus ();

    r4_frac_div_seq #(.WIDTH(WIDTH), .QDS_ARCH(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    r4_qds_v3 #(.QDS_ARCH(0)) u_qds0 (.est_i(qy), .idx_i(qi), .digit_o(qd0));
    r4_qds_v3 #(.QDS_ARCH(1)) u_qds1 (.est_i(qy), .idx_i(qi), .digit_o(qd1));
    r4_qds_v3 #(.QDS_ARCH(2)) u_qds2 (.est_i(qy), .idx_i(qi), .digit_o(qd2));

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] ref_sel(input int i, input int y);
        if (y >= t_p2[i]) return 5'b00001;
        if (y >= t_p1[i]) return 5'b00010;
        if (y >= t_z[i])  return 5'b00100;
        if (y >= t_m1[i]) return 5'b01000;
        return 5'b10000;
    endfunction

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] d);
        logic [63:0] num;
        exp_t        e;
        num  = 64'(x) << (2 * (N - 1));
        e.quo = QW'(num / 64'(d));
        e.rz  = ((num % 64'(d)) == 64'd0);
        return e;
    endfunction

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_start_ready"}, 64'(bus.start_ready_o), 64'd1);
        check_val({tag, "_finish_valid"}, 64'(bus.finish_valid_o), 64'd0);
        check_val({tag, "_quo"}, 64'(bus.quo_o), 64'd0);
        check_val({tag, "_rem_zero"}, 64'(bus.rem_zero_o), 64'd0);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] d, input int hold);
        int            lat;
        exp_t          e;
        logic [QW-1:0] q_seen;
        logic          rz_seen;
        check_val("start_ready_idle", 64'(bus.start_ready_o), 64'd1);
        bus.finish_ready_i = (hold == 0);
        bus.start_valid_i  = 1'b1;
        bus.dividend_i     = x;
        bus.divisor_i      = d;
        sb.push_back(model(x, d));
        tick();
        bus.start_valid_i = 1'b0;
        check_val("busy_after_accept", 64'(bus.start_ready_o), 64'd0);
        lat = 0;
        while (!bus.finish_valid_o && lat < 40) begin
            tick();
            lat++;
        end
        check_val("latency", 64'(lat), 64'(N + 1));
        e = sb.pop_front();
        check_val("quo", 64'(bus.quo_o), 64'(e.quo));
        check_val("rem_zero", 64'(bus.rem_zero_o), 64'(e.rz));
        q_seen  = bus.quo_o;
        rz_seen = bus.rem_zero_o;
        for (int k = 0; k < hold; k++) begin
            tick();
            check_val("hold_valid", 64'(bus.finish_valid_o), 64'd1);
            check_val("hold_quo", 64'(bus.quo_o), 64'(q_seen));
            check_val("hold_rem_zero", 64'(bus.rem_zero_o), 64'(rz_seen));
            check_val("hold_start_ready", 64'(bus.start_ready_o), 64'd0);
        end
        bus.finish_ready_i = 1'b1;
        tick();
        check_val("idle_after_hs", 64'(bus.start_ready_o), 64'd1);
        check_val("valid_drop_after_hs", 64'(bus.finish_valid_o), 64'd0);
    endtask

    task automatic expect_no_result(input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            seen |= bus.finish_valid_o;
        end
        check_val(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r1, r2;
        rst_n              = 1'b0;
        bus.start_valid_i  = 1'b0;
        bus.dividend_i     = '0;
        bus.divisor_i      = '0;
        bus.flush_i        = 1'b0;
        bus.finish_ready_i = 1'b1;
        qy = '0;
        qi = '0;
        tick();
        tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            for (int y = -64; y < 64; y++) begin
                qi = 3'(i);
                qy = 7'(y);
                #1;
                check_val("qds_arch0", 64'(qd0), 64'(ref_sel(i, y)));
                check_val("qds_arch1", 64'(qd1), 64'(ref_sel(i, y)));
                check_val("qds_arch2", 64'(qd2), 64'(ref_sel(i, y)));
            end
        end

        run_op(24'h800000, 24'h800000, 0);
        run_op(24'hC00000, 24'h800000, 0);
        run_op(24'hFFFFFF, 24'h800000, 0);
        run_op(24'h800000, 24'hFFFFFF, 0);
        run_op(24'hFFFFFF, 24'hFFFFFF, 0);
        run_op(24'h800000, 24'hC00000, 5);

        bus.start_valid_i = 1'b1;
        bus.dividend_i    = 24'hA00000;
        bus.divisor_i     = 24'hE00000;
        tick();
        bus.start_valid_i = 1'b0;
        repeat (6) tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check_val("flush_iter_valid", 64'(bus.finish_valid_o), 64'd0);
        check_val("flush_iter_idle", 64'(bus.start_ready_o), 64'd1);
        expect_no_result("flush_iter_no_result");

        bus.start_valid_i = 1'b1;
        bus.flush_i       = 1'b1;
        tick();
        bus.start_valid_i = 1'b0;
        bus.flush_i       = 1'b0;
        check_val("flush_start_not_accepted", 64'(bus.start_ready_o), 64'd1);
        expect_no_result("flush_start_no_result");

        bus.start_valid_i = 1'b1;
        bus.dividend_i    = 24'h900000;
        bus.divisor_i     = 24'hB00000;
        tick();
        bus.start_valid_i = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        check_reset_vals("reset_mid_iter");
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 150; k++) begin
            r1 = $urandom();
            r2 = $urandom();
            run_op({1'b1, r1[WIDTH-2:0]}, {1'b1, r2[WIDTH-2:0]}, (k % 25 == 0) ? 2 : 0);
        end

        check_val("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
